// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state type,
// frame geometry and the baud divisor helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Clock cycles per serial bit; integer division truncates.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Request/status bundle between a byte producer and the UART transmitter.
// Handshake: send_i is a single-cycle strobe with no ready; it is accepted
// only while busy_o is low, data_i is sampled in that same cycle, and any
// strobe seen while busy_o is high (including the done_o cycle) is dropped.
interface uart_tx_if;
    import uart_pkg::*;

    logic                 send_i;
    logic [DATA_BITS-1:0] data_i;
    logic                 tx_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (output send_i, data_i, input tx_o, busy_o, done_o);
    modport slave  (input send_i, data_i, output tx_o, busy_o, done_o);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each period; clear_i restarts the period so a frame starts bit-aligned.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    output logic tick_o,
    output logic pre_tick_o
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Period counter; tick is registered one cycle ahead so it lines up with LAST.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clear_i) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
            r_tick <= (r_cnt == PRE);
        end
    end

    assign tick_o     = r_tick;
    // Second-to-last cycle of the period, used to register end-of-period flags.
    assign pre_tick_o = (r_cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, stop bit.
// tx_o, busy_o and done_o all come straight from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    uart_tx_if.slave  bus,
    output tx_state_t state_o
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

    if (CLKS_PER_BIT < 2) begin : g_bad_cfg
        $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end

    tx_state_t            r_state, w_state_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [2:0]           r_bit, w_bit_next;
    logic                 r_tx, w_tx_next;
    logic                 r_busy, w_busy_next;
    logic                 r_done, w_done_next;
    logic                 w_accept;
    logic                 w_tick;
    logic                 w_pre_tick;

    assign w_accept = (r_state == IDLE) && bus.send_i;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clear_i    (w_accept),
        .tick_o     (w_tick),
        .pre_tick_o (w_pre_tick)
    );

    // State, datapath and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state logic; outputs are derived from the next state so the flops
    // present each bit in the same cycle the state enters it.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_done_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.send_i) begin
                    w_state_next = START;
                    w_shift_next = bus.data_i;
                    w_bit_next   = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                    w_bit_next   = '0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit == 3'(DATA_BITS - 1)) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            STOP: begin
                // Registered one cycle early so done_o lands on the last stop cycle.
                w_done_next = w_pre_tick;
                if (w_tick) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        w_tx_next = 1'b1;
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
        w_busy_next = (w_state_next != IDLE);
    end

    assign bus.tx_o   = r_tx;
    assign bus.busy_o = r_busy;
    assign bus.done_o = r_done;
    assign state_o    = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed + randomized bench for uart_tx at 16 clocks per bit.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int CPB      = 16;
    localparam int FRAME    = 10 * CPB;

    localparam int M_PLAIN  = 0;
    localparam int M_IGNORE = 1;
    localparam int M_HOLD   = 2;
    localparam int M_DONE   = 3;
    localparam int M_RESET  = 4;

    logic      clk_i   = 1'b0;
    logic      rst_n_i = 1'b0;
    tx_state_t state_o;
    int        n_cmp   = 0;
    int        n_err   = 0;
    int        cyc     = 0;
    logic [7:0] exp_q[$];

    uart_tx_if bus();

    uart_tx #(
        .CLK_FREQ_HZ(CLK_FREQ),
        .BAUD_RATE  (BAUD)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus),
        .state_o (state_o)
    );

    // Clock and cycle counter
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference line level t cycles after the accepting cycle of byte d.
    function automatic logic exp_line(input logic [7:0] d, input int t);
        int idx;
        if (t < 1 || t > FRAME) return 1'b1;
        idx = (t - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return d[idx-1];
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"},   bus.tx_o,   8'd1);
        chk({tag, "_busy"}, bus.busy_o, 8'd0);
        chk({tag, "_done"}, bus.done_o, 8'd0);
    endtask

    // Send byte d and check every cycle of the frame plus 'post' idle cycles.
    task automatic frame(input logic [7:0] d, input int mode, input int post);
        @(posedge clk_i); #1;
        bus.send_i = 1'b1;
        bus.data_i = d;
        exp_q.delete();
        exp_q.push_back(8'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back({7'd0, d[i]});
        exp_q.push_back(8'd1);
        @(negedge clk_i);
        chk("pre_busy", bus.busy_o, 8'd0);
        chk("pre_tx",   bus.tx_o,   8'd1);
        for (int t = 1; t <= FRAME + post; t++) begin
            @(posedge clk_i); #1;
            bus.send_i = 1'b0;
            if (mode == M_IGNORE && t == 50) begin
                bus.send_i = 1'b1;
                bus.data_i = 8'h3C;
            end
            if (mode == M_HOLD) bus.data_i = 8'($urandom);
            if (mode == M_DONE && t == FRAME) begin
                bus.send_i = 1'b1;
                bus.data_i = 8'($urandom);
            end
            if (mode == M_RESET && t == 70) begin
                rst_n_i = 1'b0;
                #1;
                chk_idle("async_rst");
                chk("async_rst_state", state_o, IDLE);
                return;
            end
            @(negedge clk_i);
            chk("tx",   bus.tx_o,   {7'd0, exp_line(d, t)});
            chk("busy", bus.busy_o, (t <= FRAME) ? 8'd1 : 8'd0);
            chk("done", bus.done_o, (t == FRAME) ? 8'd1 : 8'd0);
            if (t <= FRAME && (t - 1) % CPB == CPB / 2) begin
                chk("mid_bit", {7'd0, bus.tx_o}, exp_q.pop_front());
            end
        end
        chk("queue_empty", 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        bus.send_i = 1'b0;
        bus.data_i = 8'h00;
        rst_n_i    = 1'b0;

        // Reset and idle
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        chk_idle("in_reset");
        chk("in_reset_state", state_o, IDLE);
        rst_n_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            chk_idle("idle");
        end

        // Single frame
        frame(8'hA5, M_PLAIN, 20);
        // Request during a frame is dropped; nothing follows
        frame(8'h0F, M_IGNORE, 40);
        // Request in done cycle ignored, next one accepted right after
        frame(8'h96, M_DONE, 0);
        frame(8'hFF, M_PLAIN, 10);
        // data_i wiggles during the frame
        frame(8'h81, M_HOLD, 10);
        // Mid-frame reset, then a clean frame
        frame(8'hC3, M_RESET, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk_idle("held_rst");
        end
        rst_n_i = 1'b1;
        frame(8'h55, M_PLAIN, 10);

        // Random bytes with random gaps
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk_i);
            frame(8'($urandom), M_PLAIN, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
